// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter that shares one SIZE-bit register between NUM_REQ
// requesters. Each load is announced by a one-cycle grant/valid pulse and is
// followed by HOLD_CYCLES locked cycles so downstream logic can consume data_o.
module ff_share_arbiter #(
    parameter int SIZE        = 1,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ*SIZE-1:0] data_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [SIZE-1:0]         data_o,
    output logic                    valid_o,
    output logic                    busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [SIZE-1:0]    lanes [NUM_REQ];
    logic               found;
    logic [NUM_REQ-1:0] win_grant;
    logic [SIZE-1:0]    win_data;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   idx;

    // Split the packed data bus into one lane per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lanes[g] = data_i[g*SIZE +: SIZE];
    end

    // Winner search: first set request starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found     = 1'b0;
        win_grant = '0;
        win_data  = '0;
        nxt_ptr   = '0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // rr_ptr + i stays below 2*NUM_REQ, so one conditional subtract wraps it
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                win_grant = NUM_REQ'(1) << idx;
                win_data  = lanes[idx];
                nxt_ptr   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // Arbitration FSM: loads the winner in IDLE, then counts down the lock in HOLD
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            data_o   <= '0;
            grant_o  <= '0;
            valid_o  <= 1'b0;
        end else begin
            grant_o <= '0;
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        data_o  <= win_data;
                        grant_o <= win_grant;
                        valid_o <= 1'b1;
                        rr_ptr  <= nxt_ptr;
                        if (HOLD_CYCLES > 0) begin
                            hold_cnt <= CNT_W'(HOLD_CYCLES);
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Requests are deliberately ignored here and not remembered
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy is a pure decode of the lock state
    assign busy_o = (state == HOLD);

endmodule
